// File: rtl/hamming_pkg.sv
// Shared SECDED helpers: Hamming geometry derived from the data width,
// plus the per-word mode encoding.
package hamming_pkg;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  // Smallest P with 2^P >= DATA_W + P + 1. Scanning downwards keeps the last (smallest) hit.
  function automatic int calc_p(input int dw);
    int p;
    p = 0;
    for (int k = 7; k >= 1; k--)
      if ((1 << k) >= dw + k + 1) p = k;
    return p;
  endfunction

  function automatic int calc_n(input int dw);
    return dw + calc_p(dw);
  endfunction

  function automatic int calc_cw(input int dw);
    return calc_n(dw) + 1;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome (XOR of indices of set Hamming positions 1..N)
// and overall parity of the whole codeword.
module hamming_syndrome
  import hamming_pkg::*;
#(
  parameter int DATA_W = 11,
  localparam int P     = calc_p(DATA_W),
  localparam int N     = calc_n(DATA_W),
  localparam int CW    = calc_cw(DATA_W)
) (
  input  logic [CW-1:0] word_i,
  output logic [P-1:0]  syn_o,
  output logic          par_o
);

  always_comb begin
    syn_o = '0;
    for (int i = 1; i <= N; i++)
      if (word_i[i-1]) syn_o = syn_o ^ P'(i);
    par_o = ^word_i;
  end

endmodule

// File: rtl/hamming_secded_pipe.sv
// Two-stage SECDED encoder/decoder with valid/ready flow control and
// saturating error counters. Mode rides along with each word.
module hamming_secded_pipe
  import hamming_pkg::*;
#(
  parameter int DATA_W = 11,
  parameter int CNT_W  = 16,
  localparam int P     = calc_p(DATA_W),
  localparam int N     = calc_n(DATA_W),
  localparam int CW    = calc_cw(DATA_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_data,
  output logic             out_err_single,
  output logic             out_err_double,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] cnt_single,
  output logic [CNT_W-1:0] cnt_double
);

  // Data bits fill non-power-of-2 positions in ascending order.
  function automatic logic [CW-1:0] scatter(input logic [DATA_W-1:0] d);
    logic [CW-1:0] w;
    int j;
    w = '0;
    j = 0;
    for (int pos = 1; pos <= N; pos++)
      if ((pos & (pos - 1)) != 0) begin
        w[pos-1] = d[j];
        j++;
      end
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] gather(input logic [CW-1:0] w);
    logic [DATA_W-1:0] d;
    int j;
    d = '0;
    j = 0;
    for (int pos = 1; pos <= N; pos++)
      if ((pos & (pos - 1)) != 0) begin
        d[j] = w[pos-1];
        j++;
      end
    return d;
  endfunction

  logic [2:1]    vld_q;
  logic          s2_adv;
  logic          s1_mode_q;
  logic [CW-1:0] s1_word_q;
  logic [P-1:0]  s1_syn_q;
  logic          s1_par_q;

  logic [CW-1:0] syn_in;
  logic [P-1:0]  syn_c;
  logic          par_c;

  logic [CW-1:0] res_d, fix;
  logic          single_d, double_d;
  logic [CW-1:0] out_data_q;
  logic          single_q, double_q;
  logic [CNT_W-1:0] cnt_s_q, cnt_d_q;

  assign s2_adv   = !vld_q[2] || out_ready;
  assign in_ready = !vld_q[1] || s2_adv;

  // Encode reuses the syndrome unit: with parity slots zeroed, S is the parity vector.
  assign syn_in = (mode == MODE_DEC) ? in_data : scatter(in_data[DATA_W-1:0]);

  hamming_syndrome #(.DATA_W(DATA_W)) u_syn (
    .word_i (syn_in),
    .syn_o  (syn_c),
    .par_o  (par_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q[1]  <= 1'b0;
      s1_mode_q <= MODE_ENC;
      s1_word_q <= '0;
      s1_syn_q  <= '0;
      s1_par_q  <= 1'b0;
    end else if (in_ready) begin
      vld_q[1] <= in_valid;
      if (in_valid) begin
        s1_mode_q <= mode;
        s1_word_q <= syn_in;
        s1_syn_q  <= syn_c;
        s1_par_q  <= par_c;
      end
    end
  end

  always_comb begin
    fix      = s1_word_q;
    res_d    = '0;
    single_d = 1'b0;
    double_d = 1'b0;
    if (s1_mode_q == MODE_ENC) begin
      for (int k = 0; k < P; k++)
        fix[(1 << k) - 1] = s1_syn_q[k];
      fix[N] = ^fix[N-1:0];
      res_d  = fix;
    end else begin
      if (s1_par_q) begin
        if (s1_syn_q == '0) begin
          single_d = 1'b1;
        end else if (int'(s1_syn_q) <= N) begin
          fix[int'(s1_syn_q) - 1] = ~fix[int'(s1_syn_q) - 1];
          single_d = 1'b1;
        end else begin
          double_d = 1'b1;
        end
      end else if (s1_syn_q != '0) begin
        double_d = 1'b1;
      end
      res_d = CW'(gather(fix));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q[2]   <= 1'b0;
      out_data_q <= '0;
      single_q   <= 1'b0;
      double_q   <= 1'b0;
    end else if (s2_adv) begin
      vld_q[2] <= vld_q[1];
      if (vld_q[1]) begin
        out_data_q <= res_d;
        single_q   <= single_d;
        double_q   <= double_d;
      end
    end
  end

  // Clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      cnt_s_q <= '0;
      cnt_d_q <= '0;
    end else if (vld_q[2] && out_ready) begin
      if (single_q && cnt_s_q != '1) cnt_s_q <= cnt_s_q + 1'b1;
      if (double_q && cnt_d_q != '1) cnt_d_q <= cnt_d_q + 1'b1;
    end
  end

  assign out_valid      = vld_q[2];
  assign out_data       = out_data_q;
  assign out_err_single = single_q;
  assign out_err_double = double_q;
  assign cnt_single     = cnt_s_q;
  assign cnt_double     = cnt_d_q;

endmodule

// File: tb/tb_hamming_secded_pipe.sv
// Scoreboard bench: directed encode/decode vectors with hand-computed codewords,
// backpressure, counter saturation/clear and mid-flight reset.
module tb_hamming_secded_pipe;

  localparam int DW = 11;
  localparam int CW = 16;
  localparam int CNTW = 2;

  typedef struct {
    logic [CW-1:0] d;
    logic          s;
    logic          dd;
  } exp_t;

  logic            clk, rst, mode, in_valid, in_ready, out_valid, out_ready;
  logic [CW-1:0]   in_data, out_data;
  logic            out_err_single, out_err_double, clr_cnt;
  logic [CNTW-1:0] cnt_single, cnt_double;

  int   checks = 0;
  int   errs   = 0;
  exp_t exp_q[$];

  hamming_secded_pipe #(.DATA_W(DW), .CNT_W(CNTW)) dut (
    .clk            (clk),
    .rst            (rst),
    .mode           (mode),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_err_single (out_err_single),
    .out_err_double (out_err_double),
    .clr_cnt        (clr_cnt),
    .cnt_single     (cnt_single),
    .cnt_double     (cnt_double)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: samples between the driving negedge and the next active edge.
  initial forever begin
    exp_t e;
    @(negedge clk);
    #2;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_output: got 0x%0h expected none", out_data);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(e.d));
        chk("err_single", 32'(out_err_single), 32'(e.s));
        chk("err_double", 32'(out_err_double), 32'(e.dd));
      end
    end
  end

  task automatic send(input logic m, input logic [CW-1:0] d,
                      input logic [CW-1:0] ed, input logic es, input logic edd);
    exp_t e;
    int n;
    @(negedge clk);
    mode = m;
    in_data = d;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errs++;
      $display("FAIL accept_timeout: in_ready 0 expected 1");
    end else begin
      e.d = ed; e.s = es; e.dd = edd;
      exp_q.push_back(e);
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded expected bound");
    $fatal(1);
  end

  initial begin
    int acc;
    rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b1; clr_cnt = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_flags", 32'({out_err_single, out_err_double}), 0);
    chk("rst_cnts", 32'({cnt_single, cnt_double}), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 32'(in_ready), 1);

    // Latency: accept edge loads stage 1, next edge presents the result.
    send(1'b0, 16'h0001, 16'h8007, 0, 0);
    @(negedge clk);
    chk("lat_stage1", 32'(out_valid), 0);
    @(negedge clk);
    chk("lat_stage2", 32'(out_valid), 1);
    drain();

    // Back-to-back words with mode switching between them.
    send(1'b1, 16'h8007, 16'h0001, 0, 0);
    send(1'b1, 16'h8003, 16'h0001, 1, 0);
    send(1'b1, 16'h0007, 16'h0001, 1, 0);
    send(1'b0, 16'h07FF, 16'hFFFF, 0, 0);
    send(1'b1, 16'h8119, 16'h0002, 1, 0);
    send(1'b1, 16'hFFFF, 16'h07FF, 0, 0);
    send(1'b0, 16'hF801, 16'h8007, 0, 0);
    send(1'b1, 16'h001E, 16'h0003, 0, 0);
    send(1'b1, 16'h8002, 16'h0000, 0, 1);
    send(1'b0, 16'h0003, 16'h001E, 0, 0);
    drain();
    chk("cnt_double_one", 32'(cnt_double), 1);
    chk("cnt_single_sat", 32'(cnt_single), 3);

    // Backpressure: only two words fit while the output is stalled.
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      mode = 1'b0;
      in_data = CW'(acc + 1);
      in_valid = 1'b1;
      if (in_ready) begin
        exp_t e;
        e.d = (acc == 0) ? 16'h8007 : 16'h8019;
        e.s = 0; e.dd = 0;
        exp_q.push_back(e);
        acc++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 2);
    chk("bp_in_ready", 32'(in_ready), 0);
    chk("bp_hold_valid", 32'(out_valid), 1);
    chk("bp_hold_data", 32'(out_data), 32'h8007);
    out_ready = 1'b1;
    send(1'b0, 16'h0003, 16'h001E, 0, 0);
    send(1'b0, 16'h0004, 16'h802A, 0, 0);
    drain();

    // Counter clear, saturation, and clear winning over an increment.
    @(negedge clk); clr_cnt = 1'b1;
    @(negedge clk); clr_cnt = 1'b0;
    chk("clr_single", 32'(cnt_single), 0);
    chk("clr_double", 32'(cnt_double), 0);
    for (int i = 0; i < 5; i++) send(1'b1, 16'h8003, 16'h0001, 1, 0);
    drain();
    chk("cnt_single_sat5", 32'(cnt_single), 3);
    out_ready = 1'b0;
    send(1'b1, 16'h0007, 16'h0001, 1, 0);
    acc = 0;
    while (!out_valid && acc < 20) begin
      @(negedge clk);
      acc++;
    end
    chk("stall_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    chk("clr_wins", 32'(cnt_single), 0);
    drain();

    // Reset with two words in flight.
    send(1'b1, 16'h8002, 16'h0000, 0, 1);
    drain();
    chk("cnt_double_pre_rst", 32'(cnt_double), 1);
    out_ready = 1'b0;
    send(1'b0, 16'h0001, 16'h8007, 0, 0);
    send(1'b0, 16'h0002, 16'h8019, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_cnts", 32'({cnt_single, cnt_double}), 0);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_stale", 32'(out_valid), 0);

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule

// File: doc/hamming_secded_pipe.md
HAMMING_SECDED_PIPE -- requirements
Module: hamming_secded_pipe

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_W, 11, data bits per word (range 4..57).
- CNT_W, 16, error-counter width.
- Derived: P = smallest integer with 2^P >= DATA_W+P+1; N = DATA_W+P; CW = N+1 (codeword incl. overall parity).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock.
- rst, in, 1, synchronous active-high reset.
- mode, in, 1, 0 = encode, 1 = decode; sampled with each accepted word.
- in_valid, in, 1, input word valid.
- in_ready, out, 1, input accepted when in_valid&&in_ready.
- in_data, in, CW, decode: codeword; encode: data in [DATA_W-1:0], upper bits ignored.
- out_valid, out, 1, output word valid.
- out_ready, in, 1, output consumed when out_valid&&out_ready.
- out_data, out, CW, encode: codeword; decode: corrected data in [DATA_W-1:0], upper bits 0.
- out_err_single, out, 1, corrected single error (decode only).
- out_err_double, out, 1, uncorrectable error (decode only).
- clr_cnt, in, 1, synchronous counter clear.
- cnt_single, out, CNT_W, saturating count of delivered single-error words.
- cnt_double, out, CNT_W, saturating count of delivered uncorrectable words.
REQ-003 One clock; reset SHALL be synchronous and active-high; ports named clk and rst.

Function
REQ-004 Codeword layout: bit i-1 = Hamming position i (1..N); parity bit p_k at position 2^k; data bits fill non-power-of-2 positions ascending (d0 at position 3); bit N = overall even parity of bits [N-1:0].
REQ-005 Parity p_k SHALL be XOR of all data positions whose index has bit k set.
REQ-006 Decode: syndrome S = XOR of indices of all set positions 1..N; O = XOR of all CW bits.
REQ-007 S=0,O=0: no error, flags 0.
REQ-008 O=1,S=0: error in overall bit; data unchanged; out_err_single=1.
REQ-009 O=1, 1<=S<=N: flip position S, extract data; out_err_single=1.
REQ-010 O=1, S>N: out_err_double=1, data extracted uncorrected.
REQ-011 O=0,S!=0: out_err_double=1, data extracted uncorrected.
REQ-012 Encode mode: both flags 0.
REQ-013 Two-stage pipeline: stage 1 registers in_data/mode and syndrome/parity; stage 2 registers encoded/corrected result and flags; latency 2 cycles from accept to out_valid without backpressure; throughput 1 word/cycle.
REQ-014 Flow control: s2 advances when !s2_valid || out_ready; s1 advances when s2 advances or !s1_valid; in_ready = !s1_valid || s1 advance (combinational, no in_valid dependency).
REQ-015 While out_valid&&!out_ready, out_data and flags SHALL hold stable; words SHALL never be dropped, duplicated or reordered.
REQ-016 Mode SHALL travel with its word; mode changes between words SHALL not affect in-flight words.
REQ-017 Counters increment by 1 on output handshake with corresponding flag; saturate at all-ones.
REQ-018 clr_cnt zeroes both counters next edge; clr_cnt with simultaneous increment: clear wins (result 0).

Reset
REQ-019 On rst: s1_valid, s2_valid, out_valid = 0; out_data = 0; flags = 0; cnt_single = cnt_double = 0; in_ready = 1 the cycle after reset is released.
REQ-020 rst mid-operation SHALL discard all in-flight words; none emerge afterwards.

Structure
REQ-021 Shared package hamming_pkg SHALL hold the P/N/CW derivation functions and the mode encoding constants (MODE_ENC=0, MODE_DEC=1).
REQ-022 One combinational sub-module hamming_syndrome (parameter DATA_W) SHALL compute S and O from a CW-bit word; encoder reuses it with parity positions zeroed.

Verification (DATA_W=11, CW=16)
REQ-023 Encode in_data=0x001 -> out_data=0x8007, flags 0, 2 cycles after accept.
REQ-024 Decode 0x8007 -> 0x001, flags 0; decode 0x8003 (position 3 flipped) -> 0x001, err_single=1; decode 0x0007 -> 0x001, err_single=1.
REQ-025 Decode 0x8002 (two bits flipped) -> err_double=1, err_single=0, cnt_double increments by 1.
REQ-026 Backpressure: 4 back-to-back encodes of 0x001..0x004, out_ready=0 for 5 cycles -> in_ready=0 after 2 accepted, out_data held at encode(0x001); after release, 4 words in order, none lost.
REQ-027 CNT_W=2: 5 single-error words -> cnt_single=3; clr_cnt asserted with a sixth single-error handshake -> cnt_single=0.
REQ-028 rst asserted with 2 words in flight -> out_valid=0 next cycle, no stale output afterwards, counters 0.
